// File: rtl/dcache_responder_pkg.sv
// ============================================================================
// Module  : dcache_responder_pkg
// Brief   : Shared state encoding, field widths and line-address helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dcache_responder_pkg;

  localparam int c_OFFSET_W = 2;
  localparam int c_WORDS    = 4;
  localparam int c_IDX_W    = 2;
  localparam int c_ADDR_W   = 16;
  localparam int c_DATA_W   = 16;
  localparam int c_TAG_W    = c_ADDR_W - c_IDX_W - c_OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2
  } cacheState_e;

  function automatic logic [c_ADDR_W-1:0] lineAddr(input logic [c_TAG_W-1:0] tag,
                                                   input logic [c_IDX_W-1:0] idx);
    return {tag, idx, {c_OFFSET_W{1'b0}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_line_store.sv
// ============================================================================
// Module  : dcache_line_store
// Brief   : Valid/dirty/tag/data arrays with one combinational read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_line_store
  import dcache_responder_pkg::*;
#(
  parameter int IDX_W  = c_IDX_W,
  parameter int TAG_W  = c_TAG_W,
  parameter int DATA_W = c_DATA_W
) (
  input  logic                        Clk,
  input  logic                        Reset_N,
  input  logic [IDX_W-1:0]            idx,
  output logic                        rdValid,
  output logic                        rdDirty,
  output logic [TAG_W-1:0]            rdTag,
  output logic [c_WORDS*DATA_W-1:0]   rdLine,
  input  logic                        wordWe,
  input  logic [c_OFFSET_W-1:0]       wordOff,
  input  logic [DATA_W-1:0]           wordData,
  input  logic                        lineWe,
  input  logic [TAG_W-1:0]            lineTag,
  input  logic [c_WORDS*DATA_W-1:0]   lineData,
  input  logic                        dirtyClr
);

  localparam int NUM_LINES = 2 ** IDX_W;

  logic [NUM_LINES-1:0]          r_valid;
  logic [NUM_LINES-1:0]          r_dirty;
  logic [TAG_W-1:0]              r_tag  [NUM_LINES];
  logic [c_WORDS*DATA_W-1:0]     r_data [NUM_LINES];

  assign rdValid = r_valid[idx];
  assign rdDirty = r_dirty[idx];
  assign rdTag   = r_tag[idx];
  assign rdLine  = r_data[idx];

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (lineWe) begin
      r_valid[idx] <= 1'b1;
      r_dirty[idx] <= 1'b0;
    end else if (wordWe) begin
      r_dirty[idx] <= 1'b1;
    end else if (dirtyClr) begin
      r_dirty[idx] <= 1'b0;
    end
  end

  // Tag and data are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge Clk) begin
    if (lineWe) begin
      r_tag[idx]  <= lineTag;
      r_data[idx] <= lineData;
    end else if (wordWe) begin
      r_data[idx][int'(wordOff)*DATA_W +: DATA_W] <= wordData;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_responder.sv
// ============================================================================
// Module  : dcache_responder
// Brief   : Direct-mapped write-back data cache on the MEM-stage data port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int IDX_W  = c_IDX_W,
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
) (
  input  logic                        Clk,
  input  logic                        Reset_N,
  input  logic                        d_readM,
  input  logic                        d_writeM,
  input  logic [ADDR_W-1:0]           d_address,
  input  logic [DATA_W-1:0]           d_wdata,
  output logic [DATA_W-1:0]           d_rdata,
  output logic                        cacheStall,
  output logic                        m_readM,
  output logic                        m_writeM,
  output logic [ADDR_W-1:0]           m_address,
  output logic [c_WORDS*DATA_W-1:0]   m_wdata,
  input  logic [c_WORDS*DATA_W-1:0]   m_rdata,
  input  logic                        m_ready,
  output logic [15:0]                 hit_count,
  output logic [15:0]                 miss_count
);

  localparam int TAG_W = ADDR_W - IDX_W - c_OFFSET_W;

  cacheState_e                r_state;
  cacheState_e                w_stateNext;
  logic [ADDR_W-1:0]          r_mAddr;
  logic [ADDR_W-1:0]          w_mAddrNext;
  logic [c_WORDS*DATA_W-1:0]  r_mWdata;
  logic [c_WORDS*DATA_W-1:0]  w_mWdataNext;
  logic [15:0]                r_hitCount;
  logic [15:0]                r_missCount;
  logic                       r_pendingMiss;

  logic [TAG_W-1:0]           w_reqTag;
  logic [IDX_W-1:0]           w_idx;
  logic [c_OFFSET_W-1:0]      w_off;
  logic                       w_req;
  logic                       w_hit;
  logic                       w_idleHit;
  logic                       w_missTake;
  logic                       w_wordWe;
  logic                       w_lineWe;
  logic                       w_dirtyClr;
  logic                       w_rdValid;
  logic                       w_rdDirty;
  logic [TAG_W-1:0]           w_rdTag;
  logic [c_WORDS*DATA_W-1:0]  w_rdLine;

  assign w_reqTag = d_address[ADDR_W-1 -: TAG_W];
  assign w_idx    = d_address[c_OFFSET_W +: IDX_W];
  assign w_off    = d_address[c_OFFSET_W-1:0];
  assign w_req    = d_readM | d_writeM;
  assign w_hit    = w_req & w_rdValid & (w_rdTag == w_reqTag);
  assign w_idleHit = (r_state == ST_IDLE) & w_hit;

  dcache_line_store #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_lineStore (
    .Clk      (Clk),
    .Reset_N  (Reset_N),
    .idx      (w_idx),
    .rdValid  (w_rdValid),
    .rdDirty  (w_rdDirty),
    .rdTag    (w_rdTag),
    .rdLine   (w_rdLine),
    .wordWe   (w_wordWe),
    .wordOff  (w_off),
    .wordData (d_wdata),
    .lineWe   (w_lineWe),
    .lineTag  (w_reqTag),
    .lineData (m_rdata),
    .dirtyClr (w_dirtyClr)
  );

  always_comb begin
    w_stateNext  = r_state;
    w_mAddrNext  = r_mAddr;
    w_mWdataNext = r_mWdata;
    w_missTake   = 1'b0;
    w_wordWe     = 1'b0;
    w_lineWe     = 1'b0;
    w_dirtyClr   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req & ~w_hit) begin
          w_missTake = 1'b1;
          if (w_rdValid & w_rdDirty) begin
            w_stateNext  = ST_WB;
            w_mAddrNext  = lineAddr(w_rdTag, w_idx);
            w_mWdataNext = w_rdLine;
          end else begin
            w_stateNext = ST_FILL;
            w_mAddrNext = lineAddr(w_reqTag, w_idx);
          end
        end else if (w_hit & d_writeM) begin
          // Store wins when both requests are raised together.
          w_wordWe = 1'b1;
        end
      end
      ST_WB: begin
        if (m_ready) begin
          w_dirtyClr  = 1'b1;
          w_mAddrNext = lineAddr(w_reqTag, w_idx);
          w_stateNext = ST_FILL;
        end
      end
      ST_FILL: begin
        if (m_ready) begin
          w_lineWe    = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state  <= ST_IDLE;
      r_mAddr  <= '0;
      r_mWdata <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_mAddr  <= w_mAddrNext;
      r_mWdata <= w_mWdataNext;
    end
  end

  // The retiring hit after a fill belongs to the miss already counted.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_hitCount    <= '0;
      r_missCount   <= '0;
      r_pendingMiss <= 1'b0;
    end else if (w_missTake) begin
      r_pendingMiss <= 1'b1;
      if (r_missCount != 16'hFFFF) r_missCount <= r_missCount + 16'd1;
    end else if (w_idleHit) begin
      if (r_pendingMiss)               r_pendingMiss <= 1'b0;
      else if (r_hitCount != 16'hFFFF) r_hitCount    <= r_hitCount + 16'd1;
    end
  end

  assign cacheStall = (w_req & ~w_hit) | (r_state != ST_IDLE);
  assign d_rdata    = w_rdLine[int'(w_off)*DATA_W +: DATA_W];
  assign m_readM    = (r_state == ST_FILL);
  assign m_writeM   = (r_state == ST_WB);
  assign m_address  = r_mAddr;
  assign m_wdata    = r_mWdata;
  assign hit_count  = r_hitCount;
  assign miss_count = r_missCount;

endmodule

`default_nettype wire
